// File: rtl/regs_file.sv
// General-purpose register file: two combinational read ports, one core write port,
// a debug read/write port and a commit counter. Define REGS_BYPASS_EN for write-to-read forwarding.
module regs_file #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg1_raddr_i,
    input  logic [ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0] reg1_rdata_o,
    output logic [DATA_W-1:0] reg2_rdata_o,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic [DATA_W-1:0] reg_wdata_i,
    input  logic              reg_wen_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    input  logic              dbg_we_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_conflict_o,
    output logic [31:0]       commit_cnt_o
);

    localparam int DEPTH = 1 << ADDR_W;

    // Entry 0 is hardwired to zero, so only entries 1..DEPTH-1 are stored.
    logic [DATA_W-1:0] regs [1:DEPTH-1];

    logic core_wr;
    logic dbg_wr;
    logic conflict;

    assign core_wr  = reg_wen_i && (reg_waddr_i != '0);
    assign dbg_wr   = dbg_we_i && (dbg_addr_i != '0);
    assign conflict = core_wr && dbg_wr && (reg_waddr_i == dbg_addr_i);

    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] addr);
        if (addr == '0) begin
            return '0;
        end
        return regs[addr];
    endfunction

    // Core write has priority over a debug write to the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (core_wr && (reg_waddr_i == ADDR_W'(i))) begin
                    regs[i] <= reg_wdata_i;
                end else if (dbg_wr && (dbg_addr_i == ADDR_W'(i))) begin
                    regs[i] <= dbg_wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_rdata_o    <= '0;
            dbg_conflict_o <= 1'b0;
            commit_cnt_o   <= '0;
        end else begin
            dbg_rdata_o    <= stored(dbg_addr_i);
            dbg_conflict_o <= conflict;
            if (core_wr) begin
                commit_cnt_o <= commit_cnt_o + 32'd1;
            end
        end
    end

    always_comb begin
        reg1_rdata_o = stored(reg1_raddr_i);
`ifdef REGS_BYPASS_EN
        if (core_wr && (reg_waddr_i == reg1_raddr_i)) begin
            reg1_rdata_o = reg_wdata_i;
        end
`endif
        if (rst) begin
            reg1_rdata_o = '0;
        end
    end

    always_comb begin
        reg2_rdata_o = stored(reg2_raddr_i);
`ifdef REGS_BYPASS_EN
        if (core_wr && (reg_waddr_i == reg2_raddr_i)) begin
            reg2_rdata_o = reg_wdata_i;
        end
`endif
        if (rst) begin
            reg2_rdata_o = '0;
        end
    end

endmodule

// File: tb/tb_regs_file.sv
// Bench for regs_file: directed vector table, reset/wrap/async-reset sequences and a
// random phase, all checked through an expected-value queue against a reference model.
module tb_regs_file;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

`ifdef REGS_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] reg1_raddr_i;
    logic [ADDR_W-1:0] reg2_raddr_i;
    logic [DATA_W-1:0] reg1_rdata_o;
    logic [DATA_W-1:0] reg2_rdata_o;
    logic [ADDR_W-1:0] reg_waddr_i;
    logic [DATA_W-1:0] reg_wdata_i;
    logic              reg_wen_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_we_i;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic              dbg_conflict_o;
    logic [31:0]       commit_cnt_o;

    regs_file #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .reg1_raddr_i   (reg1_raddr_i),
        .reg2_raddr_i   (reg2_raddr_i),
        .reg1_rdata_o   (reg1_rdata_o),
        .reg2_rdata_o   (reg2_rdata_o),
        .reg_waddr_i    (reg_waddr_i),
        .reg_wdata_i    (reg_wdata_i),
        .reg_wen_i      (reg_wen_i),
        .dbg_addr_i     (dbg_addr_i),
        .dbg_wdata_i    (dbg_wdata_i),
        .dbg_we_i       (dbg_we_i),
        .dbg_rdata_o    (dbg_rdata_o),
        .dbg_conflict_o (dbg_conflict_o),
        .commit_cnt_o   (commit_cnt_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];
    string             name_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    logic [31:0]       model_cnt;

    task automatic expect_val(input string name, input logic [DATA_W-1:0] v);
        exp_q.push_back(v);
        name_q.push_back(name);
    endtask

    task automatic compare(input logic [DATA_W-1:0] act);
        logic [DATA_W-1:0] e;
        string n;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty actual=%h required=<queued value>", act);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", n, act, e);
            end
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] ra);
        if (ra == '0) return '0;
        if (BYPASS && reg_wen_i && (reg_waddr_i == ra)) return reg_wdata_i;
        return model[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model_cnt = '0;
    endtask

    // Driver: called just after a rising edge; checks read ports at the falling
    // edge and registered outputs just after the next rising edge.
    task automatic cycle(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                         input logic wen, input logic [ADDR_W-1:0] waddr,
                         input logic [DATA_W-1:0] wdata, input logic dwe,
                         input logic [ADDR_W-1:0] daddr, input logic [DATA_W-1:0] dwdata,
                         input bit use_tab, input logic [DATA_W-1:0] e1,
                         input logic [DATA_W-1:0] e2);
        logic conf;
        reg1_raddr_i = rs1;
        reg2_raddr_i = rs2;
        reg_wen_i    = wen;
        reg_waddr_i  = waddr;
        reg_wdata_i  = wdata;
        dbg_we_i     = dwe;
        dbg_addr_i   = daddr;
        dbg_wdata_i  = dwdata;
        expect_val("reg1_rdata", use_tab ? e1 : model_read(rs1));
        expect_val("reg2_rdata", use_tab ? e2 : model_read(rs2));
        @(negedge clk);
        compare(reg1_rdata_o);
        compare(reg2_rdata_o);
        conf = dwe && wen && (daddr == waddr) && (daddr != '0);
        expect_val("dbg_rdata", (daddr == '0) ? '0 : model[daddr]);
        expect_val("dbg_conflict", {{(DATA_W-1){1'b0}}, conf});
        if (dwe && daddr != '0) model[daddr] = dwdata;
        if (wen && waddr != '0) begin
            model[waddr] = wdata;
            model_cnt    = model_cnt + 32'd1;
        end
        expect_val("commit_cnt", model_cnt);
        @(posedge clk);
        #1;
        compare(dbg_rdata_o);
        compare({{(DATA_W-1){1'b0}}, dbg_conflict_o});
        compare(commit_cnt_o);
    endtask

    task automatic idle_read(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                             input logic [ADDR_W-1:0] daddr);
        cycle(rs1, rs2, 1'b0, '0, '0, 1'b0, daddr, '0, 1'b0, '0, '0);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic              wen;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              dwe;
        logic [ADDR_W-1:0] daddr;
        logic [DATA_W-1:0] dwdata;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } vec_t;

    vec_t tab [8];

    initial begin
        tab[0] = '{5'd0, 5'd31, 1'b1, 5'd5,  32'h1234_5678, 1'b0, 5'd0, 32'h0,
                   32'h0, 32'h0};
        tab[1] = '{5'd5, 5'd5,  1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,
                   32'h1234_5678, 32'h1234_5678};
        tab[2] = '{5'd7, 5'd5,  1'b1, 5'd7,  32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,
                   BYPASS ? 32'hDEAD_BEEF : 32'h0, 32'h1234_5678};
        tab[3] = '{5'd7, 5'd7,  1'b1, 5'd3,  32'h0000_000A, 1'b1, 5'd3, 32'h0000_000B,
                   32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tab[4] = '{5'd3, 5'd0,  1'b0, 5'd0,  32'h0, 1'b0, 5'd3, 32'h0,
                   32'h0000_000A, 32'h0};
        tab[5] = '{5'd9, 5'd10, 1'b1, 5'd10, 32'h0000_0066, 1'b1, 5'd9, 32'h0000_0055,
                   32'h0, BYPASS ? 32'h0000_0066 : 32'h0};
        tab[6] = '{5'd9, 5'd10, 1'b0, 5'd0,  32'h0, 1'b1, 5'd0, 32'h0000_0077,
                   32'h0000_0055, 32'h0000_0066};
        tab[7] = '{5'd0, 5'd3,  1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0,
                   32'h0, 32'h0000_000A};

        rst = 1'b1;
        reg1_raddr_i = 5'd1;
        reg2_raddr_i = 5'd2;
        reg_wen_i = 1'b1;
        reg_waddr_i = 5'd1;
        reg_wdata_i = 32'hCAFE_F00D;
        dbg_we_i = 1'b1;
        dbg_addr_i = 5'd2;
        dbg_wdata_i = 32'hBEEF_0001;
        model_clear();

        // Writes presented during reset must be discarded.
        repeat (3) @(posedge clk);
        #1;
        expect_val("rst_reg1", '0);
        expect_val("rst_reg2", '0);
        expect_val("rst_dbg_rdata", '0);
        expect_val("rst_commit_cnt", '0);
        compare(reg1_rdata_o);
        compare(reg2_rdata_o);
        compare(dbg_rdata_o);
        compare(commit_cnt_o);
        @(negedge clk);
        reg_wen_i = 1'b0;
        dbg_we_i  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) begin
            idle_read(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i), ADDR_W'(i));
        end

        for (int i = 0; i < 8; i++) begin
            cycle(tab[i].rs1, tab[i].rs2, tab[i].wen, tab[i].waddr, tab[i].wdata,
                  tab[i].dwe, tab[i].daddr, tab[i].dwdata, 1'b1, tab[i].e1, tab[i].e2);
        end

        // Counter wrap: preload the counter to all-ones, then commit once more.
        force dut.commit_cnt_o = 32'hFFFF_FFFF;
        #1;
        release dut.commit_cnt_o;
        model_cnt = 32'hFFFF_FFFF;
        idle_read(5'd3, 5'd9, 5'd10);
        cycle(5'd12, 5'd0, 1'b1, 5'd12, 32'h0BAD_CAFE, 1'b0, 5'd12, '0, 1'b0, '0, '0);
        cycle(5'd12, 5'd0, 1'b1, 5'd0, 32'h1111_1111, 1'b0, 5'd12, '0, 1'b0, '0, '0);

        for (int i = 0; i < 60; i++) begin
            cycle(ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom,
                  1'b0, '0, '0);
        end

        // Asynchronous reset in the middle of a write burst.
        for (int i = 1; i < 5; i++) begin
            cycle(ADDR_W'(i), 5'd12, 1'b1, ADDR_W'(i + 16), 32'h5A5A_0000 + 32'(i),
                  1'b1, ADDR_W'(i + 20), 32'hA5A5_0000 + 32'(i), 1'b0, '0, '0);
        end
        reg1_raddr_i = 5'd17;
        reg2_raddr_i = 5'd12;
        reg_wen_i    = 1'b1;
        reg_waddr_i  = 5'd18;
        reg_wdata_i  = 32'h7777_7777;
        dbg_we_i     = 1'b1;
        dbg_addr_i   = 5'd22;
        dbg_wdata_i  = 32'h8888_8888;
        #2;
        rst = 1'b1;
        #1;
        expect_val("async_rst_reg1", '0);
        expect_val("async_rst_reg2", '0);
        expect_val("async_rst_dbg_rdata", '0);
        expect_val("async_rst_conflict", '0);
        expect_val("async_rst_commit_cnt", '0);
        compare(reg1_rdata_o);
        compare(reg2_rdata_o);
        compare(dbg_rdata_o);
        compare({{(DATA_W-1){1'b0}}, dbg_conflict_o});
        compare(commit_cnt_o);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reg_wen_i = 1'b0;
        dbg_we_i  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            idle_read(ADDR_W'(i), ADDR_W'((i + 16) % DEPTH), ADDR_W'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
